seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// 9-bit restoring sequential divider: one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_REMAINDER_EN to register and drive the remainder output (otherwise tied to 0).
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] dividend,
  input  logic [8:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [8:0] quotient,
  output logic [8:0] remainder,
  output logic       div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] dvd_q, dvd_d;
  logic [8:0] dvs_q, dvs_d;
  logic [8:0] rem_q, rem_d;
  logic [8:0] quo_q, quo_d;
  logic [8:0] quotient_q, quotient_d;
  logic       div_zero_q, div_zero_d;

  logic [9:0] shifted;
  logic [9:0] trial;
  logic       borrow;
  logic       q_bit;
  logic [8:0] rem_next;
  logic       unused_trial_msb;

  // Trial subtraction: a non-negative result is always below the divisor, so 9 bits hold it.
  always_comb begin
    shifted          = {rem_q, dvd_q[cnt_q]};
    {borrow, trial}  = {1'b0, shifted} - {2'b00, dvs_q};
    q_bit            = ~borrow;
    rem_next         = q_bit ? trial[8:0] : shifted[8:0];
    unused_trial_msb = trial[9] ^ shifted[9];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    quotient_d = quotient_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          cnt_d   = 4'd8;
          rem_d   = '0;
          quo_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = rem_next;
        quo_d = {quo_q[7:0], q_bit};
        if (cnt_q == 4'd0) begin
          quotient_d = {quo_q[7:0], q_bit};
          div_zero_d = (dvs_q == 9'd0);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      quotient_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      quotient_q <= quotient_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef SEQ_DIVIDER_REMAINDER_EN
  logic [8:0] remainder_q, remainder_d;

  always_comb begin
    remainder_d = remainder_q;
    if (state_q == S_BUSY && cnt_q == 4'd0) remainder_d = rem_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) remainder_q <= '0;
    else        remainder_q <= remainder_d;
  end

  assign remainder = remainder_q;
`else
  assign remainder = '0;
`endif

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign quotient = quotient_q;
  assign div_zero = div_zero_q;

endmodule
